sensor_scan_ctrl: RTL and testbench

//  Sequences the external parallel-in/serial-out sensor shift-register chain (board sensors -> FPGA).

---
 rtl/sensor_pkg.sv | 17 +
 rtl/sensor_clk_gen.sv | 59 +++++
 rtl/sensor_scan_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_sensor_scan_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor scan controller.
//   - FSM state encoding (IDLE/LOAD/SHIFT/PUBLISH)
//   - default chain length
//   - MMIO register offsets used by the CPU-side decode
package sensor_pkg;

    localparam int NUM_BITS_DEF = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_SHIFT   = 2'd2;
    localparam logic [1:0] ST_PUBLISH = 2'd3;

    localparam logic [7:0] MMIO_DATA_OFS = 8'h00;
    localparam logic [7:0] MMIO_IRQ_OFS  = 8'h04;

endpackage

// File: rtl/sensor_clk_gen.sv
// Phase generator for the sensor shift-register chain.
// Counts CLK_DIV system clocks per half period while run_i is high and
// produces the sr_clk level during shifting.
// Ports:
//   clk, reset    system clock, asynchronous active-high reset
//   run_i         1 while in LOAD or SHIFT (counter held at 0 otherwise)
//   shift_i       1 while in SHIFT (sr_clk level held low otherwise)
//   half_tick_o   last clk of the current CLK_DIV window
//   sample_o      last clk of an sr_clk low phase (capture ser_in here)
//   sr_clk_o      shift clock level
module sensor_clk_gen #(
    parameter int CLK_DIV = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    input  logic shift_i,
    output logic half_tick_o,
    output logic sample_o,
    output logic sr_clk_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;

    assign half_tick_o = run_i && (cnt_q == CNT_LAST);
    assign sample_o    = half_tick_o && shift_i && !lvl_q;
    assign sr_clk_o    = lvl_q;

    always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        if (!run_i || half_tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // Level only toggles inside SHIFT, so LOAD always keeps sr_clk low.
        if (!shift_i) begin
            lvl_d = 1'b0;
        end else if (half_tick_o) begin
            lvl_d = !lvl_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

endmodule

// File: rtl/sensor_scan_ctrl.sv
// Sensor chain scan controller: periodic and on-demand scans of a PISO
// shift-register chain (load pulse, NUM_BITS shifts, publish), with a
// sticky change interrupt.
// Optional feature macro: SENSOR_SCAN_DEBOUNCE_EN (publish a capture only
// when it equals the capture from the preceding scan).
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   scan_en               enable periodic scans every SCAN_PERIOD clocks
//   scan_req              1-cycle CPU request for an immediate scan
//   ser_in                serial data from the chain tail
//   sr_clk, pl_n          shift clock and active-low parallel load to the chain
//   data_out, data_valid  published word and its 1-cycle update strobe
//   busy                  1 in LOAD/SHIFT/PUBLISH
//   change_irq, irq_ack   sticky change interrupt and its clear
//   dbg_state             current FSM state
// Protocol: scan_req is a single-cycle request with no ready; requests that
// arrive while busy collapse into one pending scan. data_valid is a pulse
// with no back-pressure, high in the same cycle data_out takes its new value.
module sensor_scan_ctrl
    import sensor_pkg::*;
#(
    parameter int NUM_BITS    = NUM_BITS_DEF,
    parameter int CLK_DIV     = 64,
    parameter int SCAN_PERIOD = 8000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                scan_en,
    input  logic                scan_req,
    input  logic                ser_in,
    output logic                sr_clk,
    output logic                pl_n,
    output logic [NUM_BITS-1:0] data_out,
    output logic                data_valid,
    output logic                busy,
    output logic                change_irq,
    input  logic                irq_ack,
    output logic [1:0]          dbg_state
);

    localparam int PW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int SW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [PW-1:0] PERIOD_LAST = PW'(SCAN_PERIOD - 1);
    localparam logic [SW-1:0] SLOT_LAST   = SW'(NUM_BITS - 1);

    logic [1:0]          state_q, state_d;
    logic [PW-1:0]       period_q, period_d;
    logic                pending_q, pending_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [NUM_BITS-1:0] buf_q, buf_d;
    logic [NUM_BITS-1:0] data_q, data_d;
    logic                dv_q, dv_d;
    logic                chg_q, chg_d;
    logic                irq_q, irq_d;
`ifdef SENSOR_SCAN_DEBOUNCE_EN
    logic [NUM_BITS-1:0] cand_q, cand_d;
`endif

    logic half_tick, sample, tick, req;

    sensor_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk         (clk),
        .reset       (reset),
        .run_i       ((state_q == ST_LOAD) || (state_q == ST_SHIFT)),
        .shift_i     (state_q == ST_SHIFT),
        .half_tick_o (half_tick),
        .sample_o    (sample),
        .sr_clk_o    (sr_clk)
    );

    assign tick = scan_en && (period_q == PERIOD_LAST);
    assign req  = scan_req || tick;

    always_comb begin
        state_d   = state_q;
        period_d  = (!scan_en || tick) ? '0 : period_q + 1'b1;
        pending_d = pending_q;
        slot_d    = slot_q;
        buf_d     = buf_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        chg_d     = 1'b0;
`ifdef SENSOR_SCAN_DEBOUNCE_EN
        cand_d    = cand_q;
`endif
        if (state_q != ST_IDLE && req) begin
            pending_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (req || pending_q) begin
                    state_d   = ST_LOAD;
                    pending_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (half_tick) begin
                    state_d = ST_SHIFT;
                    slot_d  = '0;
                end
            end
            ST_SHIFT: begin
                if (sample) begin
                    buf_d[slot_q] = ser_in;
                end
                // End of a high phase closes the slot.
                if (half_tick && sr_clk) begin
                    if (slot_q == SLOT_LAST) begin
                        // Outputs are registered here so they are visible
                        // during the PUBLISH cycle itself.
                        state_d = ST_PUBLISH;
`ifdef SENSOR_SCAN_DEBOUNCE_EN
                        cand_d = buf_q;
                        if (buf_q == cand_q) begin
                            data_d = buf_q;
                            dv_d   = 1'b1;
                            chg_d  = (buf_q != data_q);
                        end
`else
                        data_d = buf_q;
                        dv_d   = 1'b1;
                        chg_d  = (buf_q != data_q);
`endif
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A change seen in PUBLISH beats an irq_ack in the same cycle.
        if (chg_q) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            period_q  <= '0;
            pending_q <= 1'b0;
            slot_q    <= '0;
            buf_q     <= '0;
            data_q    <= '0;
            dv_q      <= 1'b0;
            chg_q     <= 1'b0;
            irq_q     <= 1'b0;
`ifdef SENSOR_SCAN_DEBOUNCE_EN
            cand_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            pending_q <= pending_d;
            slot_q    <= slot_d;
            buf_q     <= buf_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            chg_q     <= chg_d;
            irq_q     <= irq_d;
`ifdef SENSOR_SCAN_DEBOUNCE_EN
            cand_q    <= cand_d;
`endif
        end
    end

    // chg_q is only ever high in PUBLISH, so the interrupt shows up in the
    // same cycle as data_valid.
    assign change_irq = irq_q || chg_q;
    assign data_out   = data_q;
    assign data_valid = dv_q;
    assign busy       = (state_q != ST_IDLE);
    assign pl_n       = (state_q != ST_LOAD);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Bench for sensor_scan_ctrl with NUM_BITS=8, CLK_DIV=4, SCAN_PERIOD=100.
// Build with SENSOR_SCAN_DEBOUNCE_EN defined to exercise the debounce build.
module tb_sensor_scan_ctrl;

  localparam int LAT = 4 * (2 * 8 + 1);

  logic clk = 1'b0;
  logic reset, scan_en, scan_req, ser_in, irq_ack;
  logic sr_clk, pl_n, data_valid, busy, change_irq;
  logic [7:0] data_out;
  logic [1:0] dbg_state;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // chain model
  logic [7:0] chain_val = 8'h00;
  logic [7:0] chain_q = 8'h00;
  logic sr_prev = 1'b0;

  // scoreboard / reference model
  logic [7:0] exp_q[$];
  int t_q[$];
  logic [7:0] m_last = 8'h00;
  logic [7:0] m_cand = 8'h00;
  logic [7:0] load_val = 8'h00;
  logic m_irq = 1'b0;
  logic pl_n_prev = 1'b1;
  int load_t = 0;

  sensor_scan_ctrl #(.NUM_BITS(8), .CLK_DIV(4), .SCAN_PERIOD(100)) dut (
    .clk(clk), .reset(reset), .scan_en(scan_en), .scan_req(scan_req),
    .ser_in(ser_in), .sr_clk(sr_clk), .pl_n(pl_n), .data_out(data_out),
    .data_valid(data_valid), .busy(busy), .change_irq(change_irq),
    .irq_ack(irq_ack), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // external chain: parallel load while pl_n low, shift on sr_clk rising
  always @(posedge clk) begin
    if (!pl_n) chain_q <= chain_val;
    else if (sr_clk && !sr_prev) chain_q <= {1'b0, chain_q[7:1]};
    sr_prev <= sr_clk;
  end
  assign ser_in = chain_q[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // scoreboard monitor: each scan's word is the chain value present during
  // the load pulse; it must appear exactly LAT cycles after the pulse began
  always @(negedge clk) begin
    logic chg;
    logic exp_dv;
    logic [7:0] w;
    if (reset) begin
      exp_q.delete(); t_q.delete();
      m_last = 8'h00; m_cand = 8'h00; m_irq = 1'b0; pl_n_prev = 1'b1;
    end else begin
      if (!pl_n) begin
        load_val = chain_val;
        if (pl_n_prev) load_t = cyc;
      end else if (!pl_n_prev) begin
`ifdef SENSOR_SCAN_DEBOUNCE_EN
        if (load_val == m_cand) begin exp_q.push_back(load_val); t_q.push_back(load_t); end
        m_cand = load_val;
`else
        exp_q.push_back(load_val); t_q.push_back(load_t);
`endif
      end
      exp_dv = (t_q.size() > 0) && (cyc == t_q[0] + LAT);
      check("sb_data_valid", data_valid, exp_dv);
      chg = 1'b0;
      if (exp_dv) begin
        w = exp_q.pop_front();
        void'(t_q.pop_front());
        check("sb_data_out", data_out, w);
        chg = (w != m_last);
        m_last = w;
      end
      check("sb_change_irq", change_irq, m_irq | chg);
      m_irq = chg | (m_irq & !irq_ack);
      pl_n_prev = pl_n;
    end
  end

  // driver tasks
  task automatic pulse_req();
    @(posedge clk); #1 scan_req = 1'b1;
    @(posedge clk); #1 scan_req = 1'b0;
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1 irq_ack = 1'b1;
    @(posedge clk); #1 irq_ack = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy !== 1'b0 && n < 300);
    check(name, busy, 1'b0);
  endtask

  task automatic wait_dv(output bit ok);
    int n = 0;
    do begin @(negedge clk); n++; end while (data_valid !== 1'b1 && n < 300);
    ok = (data_valid === 1'b1);
  endtask

  // follows one scan from the first pl_n=0 cycle up to data_valid
  task automatic watch_scan(output int lat, output int lows, output int pulses, output bit ok);
    int n, t0;
    logic prev;
    lat = -1; lows = 0; pulses = 0; ok = 0; n = 0; prev = 1'b0;
    do begin @(negedge clk); n++; end while (pl_n !== 1'b0 && n < 20);
    if (pl_n !== 1'b0) return;
    t0 = cyc; n = 0;
    while (data_valid !== 1'b1 && n < 200) begin
      if (!pl_n) lows++;
      if (sr_clk && !prev) pulses++;
      prev = sr_clk;
      @(negedge clk); n++;
    end
    if (data_valid === 1'b1) begin lat = cyc - t0; ok = 1; end
  endtask

  typedef struct {
    logic       ack_first;
    logic [7:0] chain;
    logic [7:0] exp_data;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] pool[4];

  initial begin
    int lat, lows, pulses, nf, prev_t, c0, hi, p, dvs;
    bit ok;
    logic plp;

    vecs[0] = '{1'b0, 8'hA5, 8'hA5, 1'b1};
    vecs[1] = '{1'b1, 8'hA5, 8'hA5, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 8'h00, 1'b1};
    vecs[3] = '{1'b1, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 8'hFF, 8'hFF, 1'b1};
    vecs[5] = '{1'b1, 8'h80, 8'h80, 1'b1};
    vecs[6] = '{1'b0, 8'h80, 8'h80, 1'b1};
    vecs[7] = '{1'b1, 8'h5A, 8'h5A, 1'b1};
    pool[0] = 8'h3C; pool[1] = 8'hC3; pool[2] = 8'h00; pool[3] = 8'h81;

    reset = 1'b1; scan_en = 1'b0; scan_req = 1'b0; irq_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sr_clk", sr_clk, 1'b0);
    check("rst_pl_n", pl_n, 1'b1);
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_change_irq", change_irq, 1'b0);
    reset = 1'b0;

`ifndef SENSOR_SCAN_DEBOUNCE_EN
    // table-driven single scans
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].ack_first) pulse_ack();
      chain_val = vecs[i].chain;
      pulse_req();
      watch_scan(lat, lows, pulses, ok);
      check($sformatf("t1_done[%0d]", i), ok, 1'b1);
      check($sformatf("t1_latency[%0d]", i), lat, LAT);
      check($sformatf("t1_load_len[%0d]", i), lows, 4);
      check($sformatf("t1_sr_pulses[%0d]", i), pulses, 8);
      check($sformatf("t1_data_out[%0d]", i), data_out, vecs[i].exp_data);
      check($sformatf("t1_change_irq[%0d]", i), change_irq, vecs[i].exp_irq);
      wait_idle("t1_idle");
    end

    // periodic scans every 100 cycles, irq set once then cleared
    chain_val = 8'h3C;
    pulse_ack();
    @(posedge clk); #1 scan_en = 1'b1;
    c0 = cyc; nf = 0; prev_t = 0; plp = 1'b1;
    for (int k = 0; k < 330; k++) begin
      @(negedge clk);
      if (!pl_n && plp) begin
        if (nf == 0) check("t2_first_start", cyc - c0, 100);
        else check("t2_period", cyc - prev_t, 100);
        prev_t = cyc; nf++;
      end
      plp = pl_n;
    end
    check("t2_scan_count", nf, 3);
    check("t2_irq_set", change_irq, 1'b1);
    pulse_ack();
    hi = 0; dvs = 0;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk);
      if (change_irq) hi++;
      if (data_valid) dvs++;
    end
    check("t2_irq_stays_clear", hi, 0);
    check("t2_scans_after_ack", dvs, 3);
    @(posedge clk); #1 scan_en = 1'b0;
    wait_idle("t2_idle");

    // irq_ack in the same cycle as a changing PUBLISH
    chain_val = 8'hC3;
    pulse_req();
    nf = 0;
    do begin @(negedge clk); nf++; end while (pl_n !== 1'b0 && nf < 20);
    c0 = cyc;
    while (cyc < c0 + LAT - 1) @(negedge clk);
    @(posedge clk); #1 irq_ack = 1'b1;
    @(negedge clk);
    check("t5_data_valid", data_valid, 1'b1);
    check("t5_irq_in_publish", change_irq, 1'b1);
    @(posedge clk); #1 irq_ack = 1'b0;
    @(negedge clk);
    check("t5_irq_kept", change_irq, 1'b1);
    wait_idle("t5_idle");

    // three requests while busy -> exactly one extra scan
    pulse_req();
    repeat (10) @(posedge clk);
    pulse_req();
    repeat (5) @(posedge clk);
    pulse_req();
    repeat (5) @(posedge clk);
    pulse_req();
    wait_dv(ok);
    check("t3_first_done", ok, 1'b1);
    p = cyc;
    @(negedge clk);
    check("t3_idle_after_publish", {busy, pl_n}, 2'b01);
    @(negedge clk);
    check("t3_load_entered", pl_n, 1'b0);
    wait_dv(ok);
    check("t3_second_latency", cyc - p, LAT + 2);
    nf = 0; plp = 1'b1;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (!pl_n && plp) nf++;
      plp = pl_n;
    end
    check("t3_no_third_scan", nf, 0);
`else
    // debounce: 0x11, 0x22, 0x22 -> only the third scan publishes
    for (int i = 0; i < 3; i++) begin
      chain_val = (i == 0) ? 8'h11 : 8'h22;
      pulse_req();
      dvs = 0;
      for (int k = 0; k < 90; k++) begin
        @(negedge clk);
        if (data_valid) dvs++;
      end
      check($sformatf("t6_valid_count[%0d]", i), dvs, (i == 2) ? 1 : 0);
    end
    check("t6_data_out", data_out, 8'h22);
    check("t6_irq", change_irq, 1'b1);
`endif

    // reset in the middle of SHIFT
    chain_val = 8'h96;
    pulse_req();
    repeat (20) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t4_pl_n", pl_n, 1'b1);
    check("t4_sr_clk", sr_clk, 1'b0);
    check("t4_busy", busy, 1'b0);
    check("t4_data_out", data_out, 8'h00);
    check("t4_data_valid", data_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    dvs = 0; nf = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (data_valid) dvs++;
      if (!pl_n) nf++;
    end
    check("t4_no_publish", dvs, 0);
    check("t4_no_restart", nf, 0);

    // randomized traffic against the scoreboard
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      scan_req = ($urandom_range(0, 99) < 2);
      irq_ack = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 99) < 3) chain_val = pool[$urandom_range(0, 3)];
      if (c % 400 == 0) scan_en = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1 scan_req = 1'b0; irq_ack = 1'b0; scan_en = 1'b0;
    repeat (200) @(negedge clk);
    check("rand_idle", busy, 1'b0);
    check("rand_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
